// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer: one request becomes 1, 2 or 4 single-byte memory accesses.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word requests.
module lsu_byte_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   asm_q, asm_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d;
  logic [7:0]              mem_wdata_q, mem_wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    misalign;

  function automatic logic [1:0] last_index(input logic [2:0] sz);
    case (sz[1:0])
      2'b00:   last_index = 2'd0;
      2'b01:   last_index = 2'd1;
      default: last_index = 2'd3;
    endcase
  endfunction

  function automatic logic size_illegal(input logic wr, input logic [2:0] sz);
    case (sz)
      3'b000, 3'b001, 3'b010: size_illegal = 1'b0;
      3'b100, 3'b101:         size_illegal = wr;
      default:                size_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [2:0] sz);
    case (sz)
      3'b000:  extend_load = {{(DATA_WIDTH-8){w[7]}}, w[7:0]};
      3'b001:  extend_load = {{(DATA_WIDTH-16){w[15]}}, w[15:0]};
      3'b100:  extend_load = {{(DATA_WIDTH-8){1'b0}}, w[7:0]};
      3'b101:  extend_load = {{(DATA_WIDTH-16){1'b0}}, w[15:0]};
      default: extend_load = w;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_size == 3'b010) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Reset must cut the byte strobe in the very cycle it arrives, so mem_we is gated here.
  assign req_ready = (state_q == IDLE) && !rst;
  assign mem_we    = mem_we_q && !rst;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = 8'h00;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          size_d  = req_size;
          wdata_d = req_wdata;
          idx_d   = 2'd0;
          asm_d   = '0;
          if (size_illegal(req_write, req_size) || misalign) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = XFER;
            mem_addr_d  = req_addr;
            mem_we_d    = req_write;
            mem_wdata_d = req_wdata[7:0];
          end
        end
      end
      XFER: begin
        if (!write_q) asm_d[{idx_q, 3'b000} +: 8] = mem_rdata;
        if (idx_q == last_index(size_q)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : extend_load(asm_d, size_q);
        end else begin
          // Address increments wrap naturally at the top of the byte space.
          idx_d       = idx_q + 2'd1;
          mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
          mem_we_d    = write_q;
          mem_wdata_d = wdata_q[{idx_d, 3'b000} +: 8];
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    write_q <= write_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
    idx_q   <= idx_d;
    asm_q   <= asm_d;
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Table-driven bench for lsu_byte_sequencer with a byte-wide memory model.
module tb_lsu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_size;
  logic [16:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:131071];
  int          wr_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  lsu_byte_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(17)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic        write;
    logic [2:0]  size;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic w, input logic [2:0] sz, input logic [16:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int lat);
    vec_t v;
    v.write = w; v.size = sz; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = 1'b0;
    v.lat = lat; v.nwr = w ? lat - 1 : 0;
    vecs.push_back(v);
  endfunction

  function automatic void add_err(input logic w, input logic [2:0] sz, input logic [16:0] a);
    vec_t v;
    v.write = w; v.size = sz; v.addr = a; v.wdata = 32'hA5A5A5A5; v.rdata = 32'h0;
    v.err = 1'b1; v.lat = 1; v.nwr = 0;
    vecs.push_back(v);
  endfunction

  // Misaligned entry: serviced normally unless the trap build rejects it.
  function automatic void add_mis(input logic w, input logic [2:0] sz, input logic [16:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd, input int lat);
    if (TRAP) add_err(w, sz, a);
    else      add(w, sz, a, wd, rd, lat);
  endfunction

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", id, nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          cyc;
    int          wr0;
    logic        got;
    logic [16:0] ea;
    @(negedge clk);
    chk(id, "ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.write; req_size = v.size;
    req_addr = v.addr; req_wdata = v.wdata;
    wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 17'h1ABCD; req_wdata = 32'hFFFFFFFF; req_write = ~v.write;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 8) begin
      cyc++;
      if (rsp_valid) got = 1'b1;
      else begin
        ea = v.addr + 17'(cyc - 1);
        chk(id, "mem_addr", 32'(mem_addr), 32'(ea));
        chk(id, "mem_we", 32'(mem_we), 32'(v.write));
        chk(id, "ready_busy", 32'(req_ready), 32'd0);
        @(negedge clk);
      end
    end
    if (!got) chk(id, "rsp_timeout", 32'd0, 32'd1);
    else begin
      chk(id, "latency", 32'(cyc), 32'(v.lat));
      chk(id, "rsp_rdata", rsp_rdata, v.rdata);
      chk(id, "rsp_err", 32'(rsp_err), 32'(v.err));
      chk(id, "ready_resp", 32'(req_ready), 32'd0);
      chk(id, "we_resp", 32'(mem_we), 32'd0);
    end
    @(negedge clk);
    chk(id, "rsp_drop", 32'(rsp_valid), 32'd0);
    chk(id, "ready_after", 32'(req_ready), 32'd1);
    chk(id, "writes", 32'(wr_cnt - wr0), 32'(v.nwr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 3'b000;
    req_addr = '0; req_wdata = '0;

    add(1'b1, 3'b010, 17'h00100, 32'hDEADBEEF, 32'h0, 5);
    add(1'b1, 3'b010, 17'h00104, 32'h00000000, 32'h0, 5);
    add(1'b1, 3'b010, 17'h00040, 32'h00000000, 32'h0, 5);
    add(1'b1, 3'b000, 17'h00020, 32'h11223380, 32'h0, 2);
    add(1'b0, 3'b010, 17'h00100, 32'h0, 32'hDEADBEEF, 5);
    add(1'b0, 3'b000, 17'h00020, 32'h0, 32'hFFFFFF80, 2);
    add(1'b0, 3'b100, 17'h00020, 32'h0, 32'h00000080, 2);
    add(1'b0, 3'b001, 17'h00100, 32'h0, 32'hFFFFBEEF, 3);
    add(1'b0, 3'b101, 17'h00102, 32'h0, 32'h0000DEAD, 3);
    add_mis(1'b1, 3'b001, 17'h1FFFF, 32'h12345678, 32'h0, 3);
    add_mis(1'b0, 3'b101, 17'h1FFFF, 32'h0, 32'h00005678, 3);
    add_mis(1'b0, 3'b001, 17'h00101, 32'h0, 32'hFFFFADBE, 3);
    add_mis(1'b0, 3'b010, 17'h00102, 32'h0, 32'h0000DEAD, 5);
    add_err(1'b0, 3'b011, 17'h00100);
    add_err(1'b1, 3'b100, 17'h00100);
    add_err(1'b1, 3'b101, 17'h00100);
    add_err(1'b0, 3'b111, 17'h00100);
    add_err(1'b0, 3'b110, 17'h00100);
    add_mis(1'b1, 3'b010, 17'h1FFFE, 32'hCAFEF00D, 32'h0, 5);
    add_mis(1'b0, 3'b010, 17'h1FFFE, 32'h0, 32'hCAFEF00D, 5);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(-1, "rst_ready", 32'(req_ready), 32'd0);
    chk(-1, "rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk(-1, "rst_rsp_err", 32'(rsp_err), 32'd0);
    chk(-1, "rst_rsp_rdata", rsp_rdata, 32'd0);
    chk(-1, "rst_mem_we", 32'(mem_we), 32'd0);
    chk(-1, "rst_mem_addr", 32'(mem_addr), 32'd0);
    chk(-1, "rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    #1;
    chk(-1, "idle_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset during the second byte of a word store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 3'b010;
    req_addr = 17'h00040; req_wdata = 32'hAABBCCDD;
    wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk(100, "first_we", 32'(mem_we), 32'd1);
    chk(100, "first_addr", 32'(mem_addr), 32'h40);
    chk(100, "first_wdata", 32'(mem_wdata), 32'hDD);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk(100, "abort_we", 32'(mem_we), 32'd0);
    chk(100, "abort_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk(100, "post_ready", 32'(req_ready), 32'd1);
    chk(100, "post_rsp", 32'(rsp_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk(100, "no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk(100, "abort_writes", 32'(wr_cnt - wr0), 32'd1);
    chk(100, "mem40", 32'(mem[17'h40]), 32'hDD);
    chk(100, "mem41", 32'(mem[17'h41]), 32'h00);
    chk(100, "mem42", 32'(mem[17'h42]), 32'h00);
    chk(100, "mem43", 32'(mem[17'h43]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
- Load/store initiator between the execute stage and a byte-wide data memory port.
- Accepts one load or store per handshake, then issues it as 1, 2 or 4 single-byte accesses, one per cycle, starting at the lowest address (little-endian).
- For loads, assembles the bytes and applies sign or zero extension per the size code, then returns a one-cycle response.
- Memory-side read is combinational: read data is valid in the same cycle as the address.

Parameters:
- DATA_WIDTH, 32, request/response data width; only 32 is supported.
- ADDR_WIDTH, 17, byte address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  3  size code: 000 b, 001 h, 010 w, 100 bu (load only), 101 hu (load only).
- req_addr  input  ADDR_WIDTH  byte address of the lowest byte.
- req_wdata  input  DATA_WIDTH  store data; low bytes are used.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  output  1  request rejected; qualified by rsp_valid.
- mem_addr  output  ADDR_WIDTH  byte address to memory.
- mem_we  output  1  byte write enable.
- mem_wdata  output  8  byte to write.
- mem_rdata  input  8  byte read; combinational with mem_addr.

Behaviour:
- Reset and idle outputs
  - While rst is high at an edge: state goes to IDLE; rsp_valid, rsp_err, rsp_rdata, mem_we, mem_addr and mem_wdata become 0.
  - req_ready is 0 during any cycle in which rst is high.
- States: IDLE, XFER, RESP.
- IDLE
  - req_ready = 1.
  - Accept when req_valid & req_ready at an edge: latch write, size, addr and wdata; clear the byte index and the assembly register.
- Byte count N
  - N = 1 for sizes 000 and 100; N = 2 for 001 and 101; N = 4 for 010.
  - Illegal requests: sizes 011, 110, 111, and stores with 100 or 101.
  - Illegal requests go IDLE -> RESP directly with rsp_err = 1 and no memory access.
- XFER
  - Lasts exactly N cycles; byte index k runs 0..N-1.
  - mem_addr = latched addr + k, wrapping modulo 2^ADDR_WIDTH.
  - Store: mem_we = 1 and mem_wdata = wdata byte k.
  - Load: mem_we = 0, and mem_rdata is captured into assembly byte k at the end of the cycle.
  - After byte N-1, go to RESP.
- Outside XFER: mem_we = 0 and mem_addr = 0.
- RESP (exactly one cycle, then IDLE)
  - rsp_valid = 1.
  - Load rsp_rdata: sizes 000/001 sign-extend from bit 7/15; sizes 100/101 zero-extend; size 010 returns the raw word.
  - Store rsp_rdata = 0.
  - req_ready = 0 in RESP and XFER.
- Latency
  - A legal request accepted at edge E0 drives its byte accesses in the N cycles after E0; rsp_valid is high in cycle N+1.
  - Illegal request: rsp_valid is high in cycle 1.
  - Minimum issue interval is N+2 cycles.
- No alignment requirement
  - Misaligned accesses proceed byte by byte, including across the top-address wrap.
- Reset mid-operation
  - Aborts immediately.
  - Bytes already written stay written; no further mem_we; no response is produced for the aborted request.
- req inputs are ignored outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a halfword request with addr[0] != 0, or a word request with addr[1:0] != 0, is treated as illegal.
  - Result: IDLE -> RESP, rsp_err = 1, rsp_rdata = 0, no memory access, rsp_valid in cycle 1.
- Undefined: misaligned requests are serviced as described in Behaviour, and rsp_err is raised only for illegal size codes.

Test Plan:
- Word load
  - Stimulus: memory 0x100..0x103 = EF, BE, AD, DE; load size 010 at 0x100.
  - Required: mem_addr sequence 0x100, 0x101, 0x102, 0x103; rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid in cycle 5 after accept.
- Byte load sign vs zero
  - Stimulus: byte 0x80 at 0x20; issue lb then lbu at 0x20.
  - Required: rsp_rdata = 0xFFFFFF80 for lb, then 0x00000080 for lbu.
- Halfword store across the wrap (macro undefined)
  - Stimulus: store size 001, addr 0x1FFFF, wdata 0x12345678.
  - Required: writes 0x78 to 0x1FFFF, then 0x56 to 0x00000; rsp_valid in cycle 3 with rdata 0.
- Illegal size
  - Stimulus: load size 011.
  - Required: rsp_valid and rsp_err = 1 in cycle 1, mem_we never asserted, req_ready high again in cycle 2.
- Reset mid-store
  - Stimulus: word store of 0xAABBCCDD at 0x40; rst high during the second XFER cycle.
  - Required: only 0x40 = DD is written; no rsp_valid; req_ready = 1 in the first cycle after rst drops.
- Misalign trap (macro defined)
  - Stimulus: lw at 0x102.
  - Required: rsp_err = 1, rsp_rdata = 0, no memory access.
